pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core. It consumes the load-use bubble request from the ID-stage hazard detector, the taken-branch flush from EX and the data-memory busy signal. It turns them into per-stage enable/flush controls for PC, IF/ID, ID/EX and the back end (EX/MEM, MEM/WB). It also guarantees exactly one bubble per load-use hazard, freezes the whole pipeline during memory wait states, flags memory timeouts, and keeps saturating stall statistics.

---
 rtl/pipeline_stall_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush controller for the 5-stage core.
// The request inputs (load-use, branch flush, dmem busy) turn into per-stage
// enable/flush controls. The controller inserts exactly one bubble per
// load-use hazard and freezes the pipeline while data memory is busy. It
// also raises a sticky error when memory stays busy too long and keeps
// saturating stall statistics.
module pipeline_stall_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_req,
    input  logic             branch_flush,
    input  logic             dmem_busy,
    input  logic             clr_stats,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             back_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [1:0]       state_dbg
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FREEZE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_FREEZE = 2'd3
    } act_t;

    state_t         state;
    act_t           act;
    logic [WW-1:0]  wait_cnt;

    assign state_dbg = state;

    // Pick this cycle's action by priority. FREEZE state with memory ready
    // evaluates like RUN, so only the BUBBLE state masks a lingering request.
    always_comb begin
        act = ACT_NORMAL;
        if (dmem_busy || mem_timeout) begin
            act = ACT_FREEZE;
        end else if (branch_flush) begin
            act = ACT_FLUSH;
        end else if (load_use_req && (state != BUBBLE)) begin
            act = ACT_BUBBLE;
        end
    end

    // Decode the action into stage controls. In reset the pipeline is held and flushed.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        back_en     = 1'b1;
        if (!rst_n) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            back_en     = 1'b0;
        end else begin
            case (act)
                ACT_FREEZE: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    back_en  = 1'b0;
                end
                ACT_FLUSH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_BUBBLE: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State register: follows the action taken this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (act)
                ACT_FREEZE: state <= FREEZE;
                ACT_BUBBLE: state <= BUBBLE;
                default:    state <= RUN;
            endcase
        end
    end

    // Consecutive busy counter. The timeout latches on the edge that would reach MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (dmem_busy) begin
            if (wait_cnt != WW'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating statistics. A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else if (clr_stats) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (act == ACT_BUBBLE && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (act == ACT_FLUSH  && flush_cnt  != '1) flush_cnt  <= flush_cnt  + CNT_W'(1);
            if (act == ACT_FREEZE && freeze_cnt != '1) freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl. The reference model tracks the controller
// in terms of actions and a handful of integers and flags. The scenarios are
// directed first, followed by randomized traffic with occasional resets.
module tb_pipeline_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic load_use_req = 1'b0, branch_flush = 1'b0, dmem_busy = 1'b0, clr_stats = 1'b0;
    logic pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, mem_timeout;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt, freeze_cnt;
    logic [1:0] state_dbg;

    pipeline_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_req(load_use_req), .branch_flush(branch_flush),
        .dmem_busy(dmem_busy), .clr_stats(clr_stats),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .back_en(back_en), .mem_timeout(mem_timeout),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
        .state_dbg(state_dbg)
    );

    // scoreboard counters
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    int  m_busy_run;
    bit  m_timeout;
    bit  m_prev_bubble;
    int  m_bubbles, m_flushes, m_freezes;
    int  m_state;   // 0 run, 1 just bubbled, 2 frozen

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_busy_run    = 0;
        m_timeout     = 0;
        m_prev_bubble = 0;
        m_bubbles     = 0;
        m_flushes     = 0;
        m_freezes     = 0;
        m_state       = 0;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_pc_en", pc_en, 0);
        check("rst_if_id_en", if_id_en, 0);
        check("rst_back_en", back_en, 0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_id_ex_flush", id_ex_flush, 1);
        check("rst_timeout", mem_timeout, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_freeze_cnt", freeze_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // driver: apply one cycle of inputs, check outputs, advance the model
    task automatic step(input bit lu, input bit br, input bit busy, input bit clr);
        int act;  // 0 normal, 1 bubble, 2 flush, 3 freeze
        load_use_req = lu;
        branch_flush = br;
        dmem_busy    = busy;
        clr_stats    = clr;
        #4;
        if (busy || m_timeout)              act = 3;
        else if (br)                        act = 2;
        else if (lu && !m_prev_bubble)      act = 1;
        else                                act = 0;
        check("pc_en", pc_en, (act == 0 || act == 2) ? 1 : 0);
        check("if_id_en", if_id_en, (act == 0 || act == 2) ? 1 : 0);
        check("back_en", back_en, (act == 3) ? 0 : 1);
        check("if_id_flush", if_id_flush, (act == 2) ? 1 : 0);
        check("id_ex_flush", id_ex_flush, (act == 1 || act == 2) ? 1 : 0);
        check("mem_timeout", mem_timeout, 32'(m_timeout));
        check("bubble_cnt", bubble_cnt, m_bubbles);
        check("flush_cnt", flush_cnt, m_flushes);
        check("freeze_cnt", freeze_cnt, m_freezes);
        check("state", state_dbg, m_state);
        @(posedge clk);
        m_prev_bubble = (act == 1);
        m_state = (act == 3) ? 2 : (act == 1) ? 1 : 0;
        if (busy) begin
            m_busy_run++;
            if (m_busy_run == MAX_WAIT) m_timeout = 1;
        end else begin
            m_busy_run = 0;
        end
        if (clr) begin
            m_bubbles = 0; m_flushes = 0; m_freezes = 0;
        end else begin
            if (act == 1) m_bubbles = sat_inc(m_bubbles);
            if (act == 2) m_flushes = sat_inc(m_flushes);
            if (act == 3) m_freezes = sat_inc(m_freezes);
        end
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // idle after reset
        repeat (2) step(0, 0, 0, 0);

        // lingering load-use request: bubble, normal, bubble
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lu_bubble_total", bubble_cnt, 2);

        // branch and load-use together: flush wins
        do_reset();
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("br_lu_flush_cnt", flush_cnt, 1);
        check("br_lu_bubble_cnt", bubble_cnt, 0);

        // short freeze with branch held, flush right after busy drops
        do_reset();
        repeat (3) step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("freeze_then_flush_freeze", freeze_cnt, 3);
        check("freeze_then_flush_flush", flush_cnt, 1);

        // timeout: busy for 6 cycles, stays frozen afterwards
        do_reset();
        repeat (6) step(0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0);
        check("timeout_sticky", mem_timeout, 1);

        // counter saturation then clear with simultaneous flush
        do_reset();
        repeat (9) step(0, 1, 0, 0);
        check("flush_sat", flush_cnt, CNT_MAX);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        check("flush_clr", flush_cnt, 0);

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
